// File: rtl/swing_gatherer.sv
// Packs W-bit Ai/Bi/ANDi beats into DEPTH-beat words and flags ANDi bits outside (Ai^Bi).
// Latency: out_valid rises on the edge that accepts the completing beat (or the flush).
// Backpressure: while a word is held, in_ready follows out_ready; a handoff may accept a beat in the same cycle.
module swing_gatherer #(
  parameter int W     = 4,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [W-1:0]                 Ai,
  input  logic [W-1:0]                 Bi,
  input  logic [W-1:0]                 ANDi,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W*DEPTH-1:0]           Ao_word,
  output logic [W*DEPTH-1:0]           Bo_word,
  output logic [W*DEPTH-1:0]           ANDo_word,
  output logic [$clog2(DEPTH+1)-1:0]   out_beats,
  output logic                         err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = W * DEPTH;

  typedef enum logic {FILL, HOLD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d, beats_d;
  logic [NW-1:0]   a_d, b_d, n_d;
  logic            accept;
  logic            bad_beat;

  assign in_ready  = reset && (state_q == FILL || out_ready);
  assign accept    = in_valid && in_ready;
  assign bad_beat  = |(ANDi & ~(Ai ^ Bi));
  assign out_valid = (state_q == HOLD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    beats_d = out_beats;
    a_d     = Ao_word;
    b_d     = Bo_word;
    n_d     = ANDo_word;
    case (state_q)
      FILL: begin
        if (accept) begin
          a_d[count_q*W +: W] = Ai;
          b_d[count_q*W +: W] = Bi;
          n_d[count_q*W +: W] = ANDi;
          count_d = count_q + CW'(1);
          // A beat arriving with flush is stored before the word is closed.
          if (count_q == CW'(DEPTH - 1) || flush) begin
            state_d = HOLD;
            beats_d = count_q + CW'(1);
          end
        end else if (flush && count_q != '0) begin
          state_d = HOLD;
          beats_d = count_q;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
          count_d = '0;
          beats_d = '0;
          a_d     = '0;
          b_d     = '0;
          n_d     = '0;
          if (in_valid) begin
            a_d[W-1:0] = Ai;
            b_d[W-1:0] = Bi;
            n_d[W-1:0] = ANDi;
            count_d    = CW'(1);
            // A single-beat word is already complete.
            if (DEPTH == 1) begin
              state_d = HOLD;
              beats_d = CW'(1);
            end
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      out_beats <= '0;
      Ao_word   <= '0;
      Bo_word   <= '0;
      ANDo_word <= '0;
      err       <= 1'b0;
    end else begin
      count_q   <= count_d;
      out_beats <= beats_d;
      Ao_word   <= a_d;
      Bo_word   <= b_d;
      ANDo_word <= n_d;
      if (accept && bad_beat) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_swing_gatherer.sv
// Bench for swing_gatherer: DEPTH=8 instance checked by table rows, hand sequences and a word scoreboard; DEPTH=1 instance checked directly.
module tb_swing_gatherer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ai, bi, andi;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] ao_w, bo_w, ando_w;
  logic [3:0]  out_beats;
  logic        err;

  logic [3:0]  a1, b1, n1;
  logic        v1, ir1, f1, ov1, ordy1;
  logic [3:0]  ao1, bo1, no1;
  logic        beats1;
  logic        err1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  swing_gatherer #(.W(4), .DEPTH(8)) u8 (
    .clk(clk), .reset(reset), .Ai(ai), .Bi(bi), .ANDi(andi),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .Ao_word(ao_w), .Bo_word(bo_w), .ANDo_word(ando_w),
    .out_beats(out_beats), .err(err)
  );

  swing_gatherer #(.W(4), .DEPTH(1)) u1 (
    .clk(clk), .reset(reset), .Ai(a1), .Bi(b1), .ANDi(n1),
    .in_valid(v1), .in_ready(ir1), .flush(f1),
    .out_valid(ov1), .out_ready(ordy1),
    .Ao_word(ao1), .Bo_word(bo1), .ANDo_word(no1),
    .out_beats(beats1), .err(err1)
  );

  typedef struct {
    logic [3:0] a, b, n;
    logic       fl;
    logic       exp_ovld;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] a, b, n;
    logic [3:0]  beats;
  } word_t;

  vec_t  tbl[12];
  word_t sb[$];

  logic [31:0] acc_a, acc_b, acc_n;
  int          acc_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc_clear();
    acc_a = '0; acc_b = '0; acc_n = '0; acc_cnt = 0;
  endtask

  task automatic acc_add(input logic [3:0] a, input logic [3:0] b, input logic [3:0] n);
    acc_a[acc_cnt*4 +: 4] = a;
    acc_b[acc_cnt*4 +: 4] = b;
    acc_n[acc_cnt*4 +: 4] = n;
    acc_cnt++;
  endtask

  task automatic acc_push();
    word_t w;
    w.a = acc_a; w.b = acc_b; w.n = acc_n; w.beats = 4'(acc_cnt);
    sb.push_back(w);
    acc_clear();
  endtask

  task automatic beat(input logic [3:0] a, input logic [3:0] b, input logic [3:0] n);
    ai = a; bi = b; andi = n; in_valid = 1'b1;
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      beat(tbl[i].a, tbl[i].b, tbl[i].n);
      flush = tbl[i].fl;
      out_ready = 1'b0;
      acc_add(tbl[i].a, tbl[i].b, tbl[i].n);
      if (tbl[i].exp_ovld) acc_push();
      tick();
      chk($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ovld));
      chk($sformatf("row%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
    end
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  // Every handshake seen before an edge must match the oldest expected word.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_word: got Ao_word %h expected no word", ao_w);
      end else begin
        word_t w;
        w = sb.pop_front();
        chk("sb_Ao_word", ao_w, w.a);
        chk("sb_Bo_word", bo_w, w.b);
        chk("sb_ANDo_word", ando_w, w.n);
        chk("sb_out_beats", 32'(out_beats), 32'(w.beats));
      end
    end
  end

  initial begin
    for (int k = 0; k < 8; k++) begin
      tbl[k].a = 4'(k);
      tbl[k].b = ~4'(k);
      tbl[k].n = 4'h0;
      tbl[k].fl = 1'b0;
      tbl[k].exp_ovld = (k == 7);
      tbl[k].exp_err = 1'b0;
    end
    tbl[8]  = '{a: 4'h3, b: 4'h6, n: 4'h4, fl: 1'b0, exp_ovld: 1'b0, exp_err: 1'b0};
    tbl[9]  = '{a: 4'h3, b: 4'h6, n: 4'h8, fl: 1'b0, exp_ovld: 1'b0, exp_err: 1'b1};
    tbl[10] = '{a: 4'h1, b: 4'h2, n: 4'h3, fl: 1'b0, exp_ovld: 1'b0, exp_err: 1'b1};
    tbl[11] = '{a: 4'hF, b: 4'h0, n: 4'hF, fl: 1'b1, exp_ovld: 1'b1, exp_err: 1'b1};

    acc_clear();
    reset = 1'b0;
    ai = '0; bi = '0; andi = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    a1 = '0; b1 = '0; n1 = '0; v1 = 1'b0; f1 = 1'b0; ordy1 = 1'b0;

    // Reset state, then a partial word discarded by reset.
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      beat(4'(k + 9), ~4'(k + 9), 4'h0);
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_Ao_word", ao_w, 32'h0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b1;

    // Full eight-beat word.
    apply(0, 7);
    chk("fill_Ao_word", ao_w, 32'h76543210);
    chk("fill_Bo_word", bo_w, 32'h89ABCDEF);
    chk("fill_ANDo_word", ando_w, 32'h0);
    chk("fill_out_beats", 32'(out_beats), 32'd8);
    chk("fill_in_ready", 32'(in_ready), 32'd0);

    // Backpressure: offered beat must not be taken while held.
    beat(4'h5, 4'hA, 4'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("bp%0d_Ao_word", k), ao_w, 32'h76543210);
      chk($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
    end
    beat(4'hA, 4'h5, 4'h0);
    out_ready = 1'b1;
    acc_add(4'hA, 4'h5, 4'h0);
    tick();
    chk("handoff_out_valid", 32'(out_valid), 32'd0);
    chk("handoff_Ao_word", ao_w, 32'h0000000A);
    chk("handoff_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    for (int k = 1; k < 8; k++) begin
      beat(4'(k), ~4'(k), 4'h0);
      acc_add(4'(k), ~4'(k), 4'h0);
      if (k == 7) acc_push();
      tick();
    end
    in_valid = 1'b0;
    chk("after_handoff_Ao_word", ao_w, 32'h7654321A);
    chk("after_handoff_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_Ao_word", ao_w, 32'h0);
    out_ready = 1'b0;

    // Flush of a partial word, flush in HOLD, flush when empty, flush with a beat.
    for (int k = 0; k < 3; k++) begin
      beat(4'(k), ~4'(k), 4'h0);
      acc_add(4'(k), ~4'(k), 4'h0);
      tick();
    end
    in_valid = 1'b0;
    flush = 1'b1;
    acc_push();
    tick();
    chk("flush_out_valid", 32'(out_valid), 32'd1);
    chk("flush_Ao_word", ao_w, 32'h00000210);
    chk("flush_out_beats", 32'(out_beats), 32'd3);
    tick();
    chk("flush_hold_out_beats", 32'(out_beats), 32'd3);
    flush = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    chk("flush_empty_out_valid", 32'(out_valid), 32'd0);
    flush = 1'b0;
    for (int k = 3; k < 6; k++) begin
      beat(4'(k), ~4'(k), 4'h0);
      acc_add(4'(k), ~4'(k), 4'h0);
      flush = (k == 5);
      if (k == 5) acc_push();
      tick();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_beat_out_valid", 32'(out_valid), 32'd1);
    chk("flush_beat_out_beats", 32'(out_beats), 32'd3);
    chk("flush_beat_Ao_word", ao_w, 32'h00000543);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Invariant checker: violating beat is still packed, err is sticky.
    apply(8, 11);
    chk("inv_ANDo_word", ando_w, 32'h0000F384);
    chk("inv_Ao_word", ao_w, 32'h0000F133);
    chk("inv_out_beats", 32'(out_beats), 32'd4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    beat(4'h1, 4'h2, 4'h0);
    tick();
    in_valid = 1'b0;
    chk("inv_sticky_err", 32'(err), 32'd1);
    reset = 1'b0;
    #1;
    chk("inv_reset_err", 32'(err), 32'd0);
    acc_clear();
    #3;
    reset = 1'b1;

    // DEPTH=1: one word per cycle through back-to-back handoffs.
    a1 = 4'h1; b1 = 4'hE; n1 = 4'h0; v1 = 1'b1;
    tick();
    chk("d1_out_valid", 32'(ov1), 32'd1);
    chk("d1_Ao_word", 32'(ao1), 32'h1);
    chk("d1_out_beats", 32'(beats1), 32'd1);
    chk("d1_in_ready", 32'(ir1), 32'd0);
    a1 = 4'h9;
    tick();
    chk("d1_hold_Ao_word", 32'(ao1), 32'h1);
    ordy1 = 1'b1;
    for (int k = 2; k < 6; k++) begin
      a1 = 4'(k); b1 = ~4'(k);
      tick();
      chk($sformatf("d1_stream%0d_out_valid", k), 32'(ov1), 32'd1);
      chk($sformatf("d1_stream%0d_Ao_word", k), 32'(ao1), 32'(k));
    end
    v1 = 1'b0;
    tick();
    chk("d1_drain_out_valid", 32'(ov1), 32'd0);
    ordy1 = 1'b0;

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
